pll_phase_sweep_ctrl: RTL and testbench

- Dynamic phase-alignment controller for a Gowin rPLL in dynamic phase mode (DYN_DA_EN="true"). It drives the PSDA phase-select bus.
- Per run, it sweeps every phase step, settles, waits for PLL lock, then integrates an already-synchronised phase-detector sample.
- It builds a hit map, finds the first 0->1 transition (circularly), and parks PSDA at that edge plus a programmable offset.
- Successor to the fixed-phase PLL wrappers: step count, integration length, settle time and centring offset are all parametrised.

---
 rtl/pll_phase_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pll_phase_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_sweep_ctrl.sv
// rtl/pll_phase_sweep_ctrl.sv - dynamic phase sweep and edge-centring controller for an rPLL PSDA bus
//
// Sweeps every PSDA phase step. At each step it waits a settle time, then
// waits for PLL lock, then integrates the phase-detector sample over a fixed
// window. The result is one hit-map bit per step. The controller locates the
// first circular 0->1 transition in the map and parks PSDA at that edge plus
// a centring offset.
//
// Ports:
//   clk        in   system clock (PLL reference domain)
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle run request, honoured only when idle
//   abort      in   cancel a run in progress (no done pulse)
//   pd_sample  in   synchronised phase-detector output
//   pll_lock   in   synchronised rPLL LOCK
//   psda       out  phase select to rPLL PSDA
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
//   found      out  edge located in last run
//   err        out  lock timeout in last run
//   edge_idx   out  step index of located edge
//   hit_map    out  per-step integrated decision
//   acc_last   out  raw count of the most recent integration window
module pll_phase_sweep_ctrl #(
    parameter int PS_BITS    = 4,
    parameter int ACC_LOG2   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_TO    = 1024,
    parameter int CENTER_OFF = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    pd_sample,
    input  logic                    pll_lock,
    output logic [PS_BITS-1:0]      psda,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic                    err,
    output logic [PS_BITS-1:0]      edge_idx,
    output logic [(1<<PS_BITS)-1:0] hit_map,
    output logic [ACC_LOG2:0]       acc_last
);

    localparam int N       = 1 << PS_BITS;
    localparam int ACC_N   = 1 << ACC_LOG2;
    localparam int MAX_A   = (SETTLE_CYC > ACC_N) ? SETTLE_CYC : ACC_N;
    localparam int CNT_MAX = (LOCK_TO > MAX_A) ? LOCK_TO : MAX_A;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0]    ACC_LAST_C  = CNT_W'(ACC_N - 1);
    localparam logic [ACC_LOG2:0]   ACC_HALF    = (ACC_LOG2 + 1)'(ACC_N / 2);
    localparam logic [PS_BITS-1:0]  STEP_LAST   = PS_BITS'(N - 1);
    localparam logic [PS_BITS-1:0]  OFFSET      = PS_BITS'(CENTER_OFF);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SET, ST_SETTLE, ST_LOCKW, ST_ACCUM,
        ST_EVAL, ST_SCAN, ST_FINAL, ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PS_BITS-1:0]  step_q, step_d;
    logic [PS_BITS-1:0]  scan_j_q, scan_j_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_LOG2:0]   acc_q, acc_d;
    logic [PS_BITS-1:0]  psda_q, psda_d;
    logic                found_q, found_d;
    logic                err_q, err_d;
    logic [PS_BITS-1:0]  edge_idx_q, edge_idx_d;
    logic [N-1:0]        hit_map_q, hit_map_d;
    logic [ACC_LOG2:0]   acc_last_q, acc_last_d;
    logic [PS_BITS-1:0]  scan_prev;

    // Predecessor of the scan index wraps naturally, so j=0 compares bit N-1.
    assign scan_prev = scan_j_q - PS_BITS'(1);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        scan_j_d   = scan_j_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        psda_d     = psda_q;
        found_d    = found_q;
        err_d      = err_q;
        edge_idx_d = edge_idx_q;
        hit_map_d  = hit_map_q;
        acc_last_d = acc_last_q;

        if (abort && (state_q != ST_IDLE)) begin
            // psda, hit_map and the other results are left as they stand.
            state_d = ST_IDLE;
            found_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hit_map_d  = '0;
                        err_d      = 1'b0;
                        found_d    = 1'b0;
                        edge_idx_d = '0;
                        step_d     = '0;
                        state_d    = ST_SET;
                    end
                end
                ST_SET: begin
                    psda_d  = step_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOCKW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKW: begin
                    if (pll_lock) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_ACCUM;
                    end else if (cnt_q == LOCK_LAST) begin
                        err_d   = 1'b1;
                        found_d = 1'b0;
                        psda_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (!pll_lock) begin
                        // Lost lock mid-window: this step's samples are untrustworthy.
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        acc_d = acc_q + {{ACC_LOG2{1'b0}}, pd_sample};
                        if (cnt_q == ACC_LAST_C) begin
                            state_d = ST_EVAL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    acc_last_d        = acc_q;
                    hit_map_d[step_q] = (acc_q >= ACC_HALF);
                    if (step_q == STEP_LAST) begin
                        scan_j_d = '0;
                        state_d  = ST_SCAN;
                    end else begin
                        step_d  = step_q + PS_BITS'(1);
                        state_d = ST_SET;
                    end
                end
                ST_SCAN: begin
                    if (!hit_map_q[scan_prev] && hit_map_q[scan_j_q]) begin
                        found_d    = 1'b1;
                        edge_idx_d = scan_j_q;
                        state_d    = ST_FINAL;
                    end else if (scan_j_q == STEP_LAST) begin
                        found_d    = 1'b0;
                        edge_idx_d = '0;
                        state_d    = ST_FINAL;
                    end else begin
                        scan_j_d = scan_j_q + PS_BITS'(1);
                    end
                end
                ST_FINAL: begin
                    // Power-of-two step count: truncating the sum is the modulo.
                    psda_d  = found_q ? (edge_idx_q + OFFSET) : '0;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            scan_j_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            psda_q     <= '0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
            edge_idx_q <= '0;
            hit_map_q  <= '0;
            acc_last_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            scan_j_q   <= scan_j_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            psda_q     <= psda_d;
            found_q    <= found_d;
            err_q      <= err_d;
            edge_idx_q <= edge_idx_d;
            hit_map_q  <= hit_map_d;
            acc_last_q <= acc_last_d;
        end
    end

    assign psda     = psda_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign found    = found_q;
    assign err      = err_q;
    assign edge_idx = edge_idx_q;
    assign hit_map  = hit_map_q;
    assign acc_last = acc_last_q;

endmodule

// File: tb/tb_pll_phase_sweep_ctrl.sv
// tb/tb_pll_phase_sweep_ctrl.sv - directed self-checking bench for pll_phase_sweep_ctrl
module tb_pll_phase_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pd_sample = 1'b0;
    logic        pll_lock = 1'b1;
    logic [3:0]  psda;
    logic        busy;
    logic        done;
    logic        found;
    logic        err;
    logic [3:0]  edge_idx;
    logic [15:0] hit_map;
    logic [4:0]  acc_last;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Plant model controls
    int          pd_mode = 0;
    logic [15:0] pd_mask = 16'h0000;
    int          lock_mode = 0;
    int          since = 0;
    logic [3:0]  prev_psda = 4'd0;
    logic [4:0]  acc_seen [16];

    pll_phase_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pd_sample (pd_sample),
        .pll_lock  (pll_lock),
        .psda      (psda),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .err       (err),
        .edge_idx  (edge_idx),
        .hit_map   (hit_map),
        .acc_last  (acc_last)
    );

    always #5 clk = ~clk;

    // Plant: tracks cycles since the last PSDA change and drives the
    // phase detector and lock a little after each rising edge.
    always @(posedge clk) begin
        #2;
        if (psda != prev_psda) begin
            if (prev_psda != 4'd15 && psda == prev_psda + 4'd1)
                acc_seen[prev_psda] = acc_last;
            since = 0;
        end else begin
            since = since + 1;
        end
        prev_psda = psda;
        if (pd_mode == 0)
            pd_sample = pd_mask[psda];
        else
            pd_sample = (psda == 4'd3 && since >= 9 && since <= 16) ||
                        (psda == 4'd9 && since >= 9 && since <= 15);
        case (lock_mode)
            1:       pll_lock = !(psda == 4'd7 && since == 12);
            2:       pll_lock = (psda != 4'd3);
            default: pll_lock = 1'b1;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input string tag, input logic with_abort);
        int  cyc;
        logic busy_bad;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        busy_bad = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (!busy) busy_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_no_timeout"}, 32'(cyc < 5000), 32'd1);
        check_eq({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] map,
                                input logic fnd, input logic [3:0] edg, input logic [3:0] ps);
        check_eq({tag, "_hit_map"}, 32'(hit_map), 32'(map));
        check_eq({tag, "_found"}, 32'(found), 32'(fnd));
        check_eq({tag, "_edge_idx"}, 32'(edge_idx), 32'(edg));
        check_eq({tag, "_psda"}, 32'(psda), 32'(ps));
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        int dn;

        repeat (3) @(negedge clk);
        check_eq("rst_psda", 32'(psda), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_hit_map", 32'(hit_map), 32'd0);
        check_eq("rst_flags", 32'({found, err, edge_idx, acc_last}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Main patterns
        pd_mode = 0;
        pd_mask = 16'h3FC0;
        do_run("pat_a", 1'b0);
        check_result("pat_a", 16'h3FC0, 1'b1, 4'd6, 4'd10);

        pd_mask = 16'h003F;
        do_run("pat_wrap", 1'b0);
        check_result("pat_wrap", 16'h003F, 1'b1, 4'd0, 4'd4);

        pd_mask = 16'hE003;
        do_run("pat_wrap2", 1'b0);
        check_result("pat_wrap2", 16'hE003, 1'b1, 4'd13, 4'd1);

        // Start together with abort in IDLE: start must win
        pd_mask = 16'hFFFF;
        do_run("all_ones", 1'b1);
        check_result("all_ones", 16'hFFFF, 1'b0, 4'd0, 4'd0);

        pd_mask = 16'h0000;
        do_run("all_zeros", 1'b0);
        check_result("all_zeros", 16'h0000, 1'b0, 4'd0, 4'd0);

        // Threshold: 8 of 16 at step 3, 7 of 16 at step 9
        pd_mode = 1;
        do_run("thresh", 1'b0);
        check_result("thresh", 16'h0008, 1'b1, 4'd3, 4'd7);
        check_eq("thresh_acc8", 32'(acc_seen[3]), 32'd8);
        check_eq("thresh_acc7", 32'(acc_seen[9]), 32'd7);
        pd_mode = 0;

        // Lock drop mid-ACCUM at step 7: step repeats with a clean count
        pd_mask = 16'h3FC0;
        lock_mode = 1;
        do_run("lock_drop", 1'b0);
        check_result("lock_drop", 16'h3FC0, 1'b1, 4'd6, 4'd10);
        check_eq("lock_drop_acc7", 32'(acc_seen[7]), 32'd16);
        lock_mode = 0;

        // Lock held low from step 3: timeout
        pd_mask = 16'h0000;
        lock_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (psda != 4'd3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("lockto_reach_step3", 32'(n < 500), 32'd1);
        n = 0;
        while (!err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("lockto_cycles", 32'(n), 32'd1032);
        check_eq("lockto_done", 32'(done), 32'd1);
        check_eq("lockto_found", 32'(found), 32'd0);
        check_eq("lockto_psda", 32'(psda), 32'd0);
        @(negedge clk);
        check_eq("lockto_done_pulse", 32'(done), 32'd0);
        check_eq("lockto_err_held", 32'(err), 32'd1);
        lock_mode = 0;

        // Abort during ACCUM of step 5
        pd_mask = 16'h3FC0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(psda == 4'd5 && since == 12) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reach", 32'(n < 1000), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_psda", 32'(psda), 32'd5);
        check_eq("abort_found", 32'(found), 32'd0);
        check_eq("abort_hit_map", 32'(hit_map), 32'd0);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 32'(dn), 32'd0);
        do_run("rerun", 1'b0);
        check_result("rerun", 16'h3FC0, 1'b1, 4'd6, 4'd10);

        // Asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (psda != 4'd8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_pre_busy", 32'({busy, psda}), 32'h18);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_psda", 32'(psda), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_hit_map", 32'(hit_map), 32'd0);
        check_eq("rst_mid_rest", 32'({done, found, err, edge_idx, acc_last}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
